// File: rtl/imem_pkg.sv
// Shared types, constants and helpers for the instruction memory controller.
package imem_pkg;

    // Controller states; the controller mirrors these as plain logic constants.
    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_LOAD  = 2'd2
    } state_e;

    // Value written to every word after reset (an all-zero NOP).
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    // Fetch latency is either the bare RAM register or one extra stage.
    function automatic bit read_lat_ok(input int rl);
        return (rl == 1) || (rl == 2);
    endfunction

    // A fetch address is legal when word aligned and inside the array.
    function automatic logic addr_legal(input logic [31:0] addr, input int aw);
        return (addr[1:0] == 2'b00) && ((addr >> (aw + 2)) == 32'd0);
    endfunction

endpackage

// File: rtl/imem_if.sv
// Fetch and program-load bus between fetch logic / host loader and imem_ctrl.
//
// Handshakes: a fetch transfers in a cycle where fetch_req && fetch_ready;
// the answer is a single-cycle fetch_valid strobe with fetch_err/fetch_data.
// A load byte transfers in a cycle where load_valid && load_ready; load_start
// and load_done are single-cycle commands with no ready of their own.
interface imem_if
    import imem_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    logic                  fetch_req;
    logic [31:0]           fetch_addr;
    logic                  fetch_ready;
    logic                  fetch_valid;
    logic [DATA_WIDTH-1:0] fetch_data;
    logic                  fetch_err;
    logic                  load_start;
    logic                  load_valid;
    logic [7:0]            load_byte;
    logic                  load_done;
    logic                  load_ready;
    logic                  load_ovf;
    logic [ADDR_WIDTH:0]   load_count;
    logic                  busy;

    modport master (
        output fetch_req, fetch_addr, load_start, load_valid, load_byte, load_done,
        input  fetch_ready, fetch_valid, fetch_data, fetch_err,
        input  load_ready, load_ovf, load_count, busy
    );

    modport slave (
        input  fetch_req, fetch_addr, load_start, load_valid, load_byte, load_done,
        output fetch_ready, fetch_valid, fetch_data, fetch_err,
        output load_ready, load_ovf, load_count, busy
    );
endinterface

// File: rtl/imem_ram.sv
// Single-port synchronous RAM: one write or one read per cycle, registered output.
module imem_ram
    import imem_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Array write port.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    // Read register; only a read updates it, so it holds across writes.
    always_ff @(posedge clk) begin
        if (rst)            rdata <= DATA_WIDTH'(NOP_WORD);
        else if (re && !we) rdata <= mem[addr];
    end
endmodule

// File: rtl/imem_ctrl.sv
// Instruction memory: self-clearing RAM, registered fetch port, byte-stream loader.
module imem_ctrl
    import imem_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int READ_LAT   = 1
) (
    input  logic        clk,
    input  logic        rst,
    imem_if.slave       bus,
    output logic [1:0]  state
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int BW = $clog2(NB + 1);
    localparam int RL = read_lat_ok(READ_LAT) ? READ_LAT : 1;
    localparam logic [BW-1:0] NB_C = BW'(NB);
    localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(NOP_WORD);

    localparam logic [1:0] S_CLEAR = ST_CLEAR;
    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_LOAD  = ST_LOAD;

    logic [ADDR_WIDTH-1:0] clr_addr;
    logic [ADDR_WIDTH:0]   ptr;
    logic [BW-1:0]         bidx, cnt_n, pad_shift;
    logic [DATA_WIDTH-1:0] asm_q, asm_n, pad_word;
    logic                  word_full, word_part;
    logic                  wr_pend;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  ovf, pend, v1, e1;
    logic                  fetch_rdy, fetch_acc, addr_ok, start_acc, load_rdy, byte_acc;
    logic                  rsp_valid, rsp_err;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  ram_we, ram_re;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata, ram_q;

    // Acceptance terms; a queued load write also owns the RAM port for a cycle.
    always_comb begin
        fetch_rdy = (state == S_IDLE) && !pend && !wr_pend;
        fetch_acc = bus.fetch_req && fetch_rdy;
        addr_ok   = addr_legal(bus.fetch_addr, ADDR_WIDTH);
        start_acc = bus.load_start && fetch_rdy;
        load_rdy  = (state == S_LOAD) && !ptr[ADDR_WIDTH];
        byte_acc  = bus.load_valid && load_rdy;
    end

    // Word assembly: bytes shift in MSB-first; a short final word is left-justified.
    always_comb begin
        asm_n     = byte_acc ? ((asm_q << 8) | DATA_WIDTH'(bus.load_byte)) : asm_q;
        cnt_n     = byte_acc ? bidx + 1'b1 : bidx;
        word_full = (cnt_n == NB_C);
        word_part = (state == S_LOAD) && bus.load_done && (cnt_n != '0) && !word_full;
        pad_shift = NB_C - cnt_n;
        pad_word  = asm_n << {pad_shift, 3'b000};
    end

    // Control FSM: clear sweep, idle, and byte-stream load.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_CLEAR;
            clr_addr <= '0;
            ptr      <= '0;
            bidx     <= '0;
            asm_q    <= '0;
            wr_pend  <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            ovf      <= 1'b0;
        end else begin
            wr_pend <= 1'b0;
            case (state)
                S_CLEAR: begin
                    clr_addr <= clr_addr + 1'b1;
                    if (&clr_addr) state <= S_IDLE;
                end
                S_IDLE: begin
                    if (start_acc) begin
                        state <= S_LOAD;
                        ptr   <= '0;
                        bidx  <= '0;
                        asm_q <= '0;
                        ovf   <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (bus.load_valid && ptr[ADDR_WIDTH]) ovf <= 1'b1;
                    asm_q <= asm_n;
                    bidx  <= cnt_n;
                    if (word_full || word_part) begin
                        wr_pend <= 1'b1;
                        wr_addr <= ptr[ADDR_WIDTH-1:0];
                        wr_data <= word_full ? asm_n : pad_word;
                        ptr     <= ptr + 1'b1;
                        bidx    <= '0;
                        asm_q   <= '0;
                    end
                    if (bus.load_done) state <= S_IDLE;
                end
                default: state <= S_CLEAR;
            endcase
        end
    end

    // RAM port arbitration: clear sweep, then pending load write, then fetch read.
    always_comb begin
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_addr  = bus.fetch_addr[ADDR_WIDTH+1:2];
        ram_wdata = wr_data;
        if (state == S_CLEAR) begin
            ram_we    = 1'b1;
            ram_addr  = clr_addr;
            ram_wdata = NOP;
        end else if (wr_pend) begin
            ram_we   = 1'b1;
            ram_addr = wr_addr;
        end else begin
            ram_re = fetch_acc && addr_ok;
        end
    end

    imem_ram #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_q)
    );

    // First response stage: tracks the single outstanding fetch and its error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend <= 1'b0;
            v1   <= 1'b0;
            e1   <= 1'b0;
        end else begin
            v1 <= fetch_acc;
            if (fetch_acc) e1 <= !addr_ok;
            if (fetch_acc)      pend <= 1'b1;
            else if (rsp_valid) pend <= 1'b0;
        end
    end

    generate
        if (RL == 2) begin : g_lat2
            logic                  v2, e2;
            logic [DATA_WIDTH-1:0] d2;
            // Extra output stage; data and error hold until the next response.
            always_ff @(posedge clk) begin
                if (rst) begin
                    v2 <= 1'b0;
                    e2 <= 1'b0;
                    d2 <= NOP;
                end else begin
                    v2 <= v1;
                    if (v1) begin
                        e2 <= e1;
                        d2 <= e1 ? NOP : ram_q;
                    end
                end
            end
            assign rsp_valid = v2;
            assign rsp_err   = e2;
            assign rsp_data  = d2;
        end else begin : g_lat1
            assign rsp_valid = v1;
            assign rsp_err   = e1;
            assign rsp_data  = e1 ? NOP : ram_q;
        end
    endgenerate

    assign bus.fetch_ready = fetch_rdy;
    assign bus.fetch_valid = rsp_valid;
    assign bus.fetch_err   = rsp_err;
    assign bus.fetch_data  = rsp_data;
    assign bus.load_ready  = load_rdy;
    assign bus.load_ovf    = ovf;
    assign bus.load_count  = ptr;
    assign bus.busy        = (state != S_IDLE);
endmodule

// File: tb/tb_imem_ctrl.sv
// Directed bench: two full-size memories (latency 1 and 2) driven in lockstep,
// plus a four-word memory for overflow. Responses are scored from queues.
`timescale 1ns/1ps
module tb_imem_ctrl;
    import imem_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    imem_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) ifa ();
    imem_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) ifb ();
    imem_if #(.ADDR_WIDTH(2),  .DATA_WIDTH(32)) ifc ();
    logic [1:0] state_a, state_b, state_c;

    imem_ctrl #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .READ_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa.slave), .state(state_a));
    imem_ctrl #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .READ_LAT(2)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb.slave), .state(state_b));
    imem_ctrl #(.ADDR_WIDTH(2),  .DATA_WIDTH(32), .READ_LAT(1)) dut_c (
        .clk(clk), .rst(rst), .bus(ifc.slave), .state(state_c));

    // Expected response entries: {response cycle[31:0], err, data[31:0]}.
    logic [64:0] exp_q_a[$];
    logic [64:0] exp_q_b[$];
    logic [64:0] exp_q_c[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Response monitors.
    always @(negedge clk) begin
        logic [64:0] e;
        if (ifa.fetch_valid === 1'b1) begin
            if (exp_q_a.size() == 0) check("a_stray_valid", 64'(ifa.fetch_valid), 64'd0);
            else begin
                e = exp_q_a.pop_front();
                check("a_data",  64'(ifa.fetch_data), 64'(e[31:0]));
                check("a_err",   64'(ifa.fetch_err),  64'(e[32]));
                check("a_cycle", 64'(cyc),            64'(e[64:33]));
            end
        end
    end

    always @(negedge clk) begin
        logic [64:0] e;
        if (ifb.fetch_valid === 1'b1) begin
            if (exp_q_b.size() == 0) check("b_stray_valid", 64'(ifb.fetch_valid), 64'd0);
            else begin
                e = exp_q_b.pop_front();
                check("b_data",  64'(ifb.fetch_data), 64'(e[31:0]));
                check("b_err",   64'(ifb.fetch_err),  64'(e[32]));
                check("b_cycle", 64'(cyc),            64'(e[64:33]));
            end
        end
    end

    always @(negedge clk) begin
        logic [64:0] e;
        if (ifc.fetch_valid === 1'b1) begin
            if (exp_q_c.size() == 0) check("c_stray_valid", 64'(ifc.fetch_valid), 64'd0);
            else begin
                e = exp_q_c.pop_front();
                check("c_data",  64'(ifc.fetch_data), 64'(e[31:0]));
                check("c_err",   64'(ifc.fetch_err),  64'(e[32]));
                check("c_cycle", 64'(cyc),            64'(e[64:33]));
            end
        end
    end

    // Fetch on both full-size memories in the same cycle.
    task automatic fetch_ab(input logic [31:0] addr, input logic [31:0] d, input logic er);
        int n = 0;
        while (!(ifa.fetch_ready && ifb.fetch_ready) && n < 20) begin tick(); n++; end
        check("ab_fetch_ready", 64'(ifa.fetch_ready & ifb.fetch_ready), 64'd1);
        ifa.fetch_req = 1'b1; ifa.fetch_addr = addr;
        ifb.fetch_req = 1'b1; ifb.fetch_addr = addr;
        exp_q_a.push_back({32'(cyc + 1), er, d});
        exp_q_b.push_back({32'(cyc + 2), er, d});
        tick();
        ifa.fetch_req = 1'b0;
        ifb.fetch_req = 1'b0;
        n = 0;
        while ((exp_q_a.size() + exp_q_b.size()) != 0 && n < 10) begin tick(); n++; end
        check("ab_rsp_outstanding", 64'(exp_q_a.size() + exp_q_b.size()), 64'd0);
        exp_q_a.delete();
        exp_q_b.delete();
    endtask

    task automatic fetch_c(input logic [31:0] addr, input logic [31:0] d, input logic er);
        int n = 0;
        while (!ifc.fetch_ready && n < 20) begin tick(); n++; end
        check("c_fetch_ready", 64'(ifc.fetch_ready), 64'd1);
        ifc.fetch_req = 1'b1; ifc.fetch_addr = addr;
        exp_q_c.push_back({32'(cyc + 1), er, d});
        tick();
        ifc.fetch_req = 1'b0;
        n = 0;
        while (exp_q_c.size() != 0 && n < 10) begin tick(); n++; end
        check("c_rsp_outstanding", 64'(exp_q_c.size()), 64'd0);
        exp_q_c.delete();
    endtask

    task automatic start_ab();
        ifa.load_start = 1'b1; ifb.load_start = 1'b1;
        tick();
        ifa.load_start = 1'b0; ifb.load_start = 1'b0;
    endtask

    task automatic byte_ab(input logic [7:0] b);
        ifa.load_valid = 1'b1; ifa.load_byte = b;
        ifb.load_valid = 1'b1; ifb.load_byte = b;
        tick();
        ifa.load_valid = 1'b0; ifb.load_valid = 1'b0;
    endtask

    task automatic done_ab();
        ifa.load_done = 1'b1; ifb.load_done = 1'b1;
        tick();
        ifa.load_done = 1'b0; ifb.load_done = 1'b0;
    endtask

    task automatic wait_clear();
        int n = 0;
        while ((ifa.busy || ifb.busy || ifc.busy) && n < 1100) begin tick(); n++; end
        check("clear_done", 64'(ifa.busy | ifb.busy | ifc.busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ca = 0, cb = 0, cc = 0;
        logic [7:0] prog [8] = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h0C};

        ifa.fetch_req = 0; ifa.fetch_addr = 0; ifa.load_start = 0;
        ifa.load_valid = 0; ifa.load_byte = 0; ifa.load_done = 0;
        ifb.fetch_req = 0; ifb.fetch_addr = 0; ifb.load_start = 0;
        ifb.load_valid = 0; ifb.load_byte = 0; ifb.load_done = 0;
        ifc.fetch_req = 0; ifc.fetch_addr = 0; ifc.load_start = 0;
        ifc.load_valid = 0; ifc.load_byte = 0; ifc.load_done = 0;

        // Reset for one cycle, then reset values.
        tick();
        rst = 1'b0;
        check("rst_fetch_valid", 64'(ifa.fetch_valid), 64'd0);
        check("rst_fetch_err",   64'(ifa.fetch_err),   64'd0);
        check("rst_fetch_data",  64'(ifa.fetch_data),  64'd0);
        check("rst_fetch_ready", 64'(ifa.fetch_ready), 64'd0);
        check("rst_load_ready",  64'(ifa.load_ready),  64'd0);
        check("rst_load_ovf",    64'(ifa.load_ovf),    64'd0);
        check("rst_load_count",  64'(ifa.load_count),  64'd0);
        check("rst_busy",        64'(ifa.busy),        64'd1);
        check("rst_b_data",      64'(ifb.fetch_data),  64'd0);
        check("rst_state",       64'(state_a),         64'(ST_CLEAR));

        // Clear sweep length: one cycle per word.
        for (int i = 0; i < 1100; i++) begin
            if (ifa.busy) ca++;
            if (ifb.busy) cb++;
            if (ifc.busy) cc++;
            tick();
        end
        check("clear_cycles_a", 64'(ca), 64'd1024);
        check("clear_cycles_b", 64'(cb), 64'd1024);
        check("clear_cycles_c", 64'(cc), 64'd4);
        check("idle_state_b",   64'(state_b), 64'(ST_IDLE));

        // Cleared contents at both ends of the array.
        fetch_ab(32'h0000_0000, 32'h0000_0000, 1'b0);
        fetch_ab(32'h0000_0FFC, 32'h0000_0000, 1'b0);

        // Two-word program load.
        start_ab();
        for (int i = 0; i < 8; i++) byte_ab(prog[i]);
        done_ab();
        check("prog_count_a", 64'(ifa.load_count), 64'd2);
        check("prog_count_b", 64'(ifb.load_count), 64'd2);
        fetch_ab(32'h0000_0000, 32'h2008_0005, 1'b0);
        fetch_ab(32'h0000_0004, 32'h0000_000C, 1'b0);
        fetch_ab(32'h0000_0008, 32'h0000_0000, 1'b0);

        // Illegal addresses: misaligned and out of range.
        fetch_ab(32'h0000_0006, 32'h0000_0000, 1'b1);
        fetch_ab(32'h0000_1000, 32'h0000_0000, 1'b1);

        // Partial word is left-justified; later words keep old contents.
        start_ab();
        byte_ab(8'hAA); byte_ab(8'hBB); byte_ab(8'hCC);
        done_ab();
        check("partial_count", 64'(ifa.load_count), 64'd1);
        fetch_ab(32'h0000_0000, 32'hAABB_CC00, 1'b0);
        fetch_ab(32'h0000_0004, 32'h0000_000C, 1'b0);

        // Fetch together with load_start returns the pre-load word.
        ifa.fetch_req = 1'b1; ifa.fetch_addr = 32'h0; ifa.load_start = 1'b1;
        ifb.fetch_req = 1'b1; ifb.fetch_addr = 32'h0; ifb.load_start = 1'b1;
        exp_q_a.push_back({32'(cyc + 1), 1'b0, 32'hAABB_CC00});
        exp_q_b.push_back({32'(cyc + 2), 1'b0, 32'hAABB_CC00});
        tick();
        ifa.fetch_req = 1'b0; ifa.load_start = 1'b0;
        ifb.fetch_req = 1'b0; ifb.load_start = 1'b0;
        check("start_busy_a", 64'(ifa.busy), 64'd1);
        check("start_busy_b", 64'(ifb.busy), 64'd1);
        check("load_fetch_ready", 64'(ifa.fetch_ready), 64'd0);
        check("load_ready_a", 64'(ifa.load_ready), 64'd1);
        byte_ab(8'h11); byte_ab(8'h22); byte_ab(8'h33); byte_ab(8'h44);
        done_ab();
        check("overlap_rsp_drained", 64'(exp_q_a.size() + exp_q_b.size()), 64'd0);
        check("overlap_count", 64'(ifb.load_count), 64'd1);
        fetch_ab(32'h0000_0000, 32'h1122_3344, 1'b0);

        // Reset in the middle of a load discards it and re-clears.
        start_ab();
        byte_ab(8'h55); byte_ab(8'h66);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_count", 64'(ifa.load_count), 64'd0);
        check("abort_busy",  64'(ifa.busy), 64'd1);
        wait_clear();
        fetch_ab(32'h0000_0000, 32'h0000_0000, 1'b0);

        // Four-word memory: 17 bytes overflow by one.
        ifc.load_start = 1'b1;
        tick();
        ifc.load_start = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            check($sformatf("c_load_ready_%0d", i), 64'(ifc.load_ready), 64'(i <= 16));
            ifc.load_valid = 1'b1; ifc.load_byte = 8'(i);
            tick();
            ifc.load_valid = 1'b0;
        end
        check("c_ovf",   64'(ifc.load_ovf),   64'd1);
        check("c_count", 64'(ifc.load_count), 64'd4);
        ifc.load_done = 1'b1;
        tick();
        ifc.load_done = 1'b0;
        fetch_c(32'h0000_0000, 32'h0102_0304, 1'b0);
        fetch_c(32'h0000_000C, 32'h0D0E_0F10, 1'b0);
        fetch_c(32'h0000_0010, 32'h0000_0000, 1'b1);

        repeat (5) tick();
        check("final_queues_empty", 64'(exp_q_a.size() + exp_q_b.size() + exp_q_c.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/imem_ctrl.md
# imem_ctrl

Parametrised instruction memory for the multicycle datapath. It replaces the file-initialised, combinational-read instruction store with a synchronous-read RAM, a registered fetch handshake and an in-system program-load port that assembles a big-endian byte stream into words. After reset it clears itself to zero (NOP). It sits between the PC/fetch logic and a host loader (testbench or UART bridge).

## Interface
- ADDR_WIDTH, 10, word-address bits; depth = 2^ADDR_WIDTH words
- DATA_WIDTH, 32, instruction word width; multiple of 8
- READ_LAT, 1, fetch latency in cycles; legal values 1 or 2
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- fetch_req  in  1  fetch request
- fetch_addr  in  32  byte address
- fetch_ready  out  1  request accepted when fetch_req & fetch_ready
- fetch_valid  out  1  one-cycle response strobe
- fetch_data  out  DATA_WIDTH  instruction; 0 on error
- fetch_err  out  1  qualifies fetch_valid: misaligned or out-of-range address
- load_start  in  1  begin program load at word 0
- load_valid  in  1  load byte present
- load_byte  in  8  program byte, MSB-first within each word
- load_done  in  1  end of program
- load_ready  out  1  byte accepted when load_valid & load_ready
- load_ovf  out  1  sticky: a byte was offered past the last word
- load_count  out  ADDR_WIDTH+1  words written in the current or last load
- busy  out  1  high in CLEAR and LOAD

## Operation
- FSM states: CLEAR, IDLE, LOAD.
- CLEAR: entered on rst. Writes 0 to word i in cycle i, so it takes 2^ADDR_WIDTH cycles, then goes to IDLE. fetch_ready and load_ready are low.
- IDLE: fetch_ready = no fetch pending.
  - Accepted fetch: address is legal when fetch_addr[1:0]==0 and fetch_addr[31:ADDR_WIDTH+2]==0.
  - Legal address: RAM read issued in the accept cycle.
  - Illegal address: the response carries fetch_err=1 and data 0.
  - Only one fetch is outstanding at a time.
- load_start: accepted in IDLE only when no fetch is pending. A fetch accepted in the same cycle is also accepted; its read has already been issued, so it returns the pre-load contents.
  - On entering LOAD: clear word pointer, byte index, load_count and load_ovf.
- LOAD:
  - load_ready = pointer < depth.
  - Each accepted byte shifts into an assembly register, first byte into bits [DATA_WIDTH-1:DATA_WIDTH-8].
  - After DATA_WIDTH/8 bytes: write the word at the pointer, then increment the pointer and load_count.
  - Pointer == depth: load_ready is low; a load_valid in that state sets load_ovf, and the byte is dropped.
  - load_done: a partial word is zero-padded in its low bytes and written. Then go to IDLE.
  - If load_done coincides with an accepted byte, the byte is included first.
  - Words beyond load_count keep their prior contents.
  - fetch_ready is low throughout LOAD.
- rst at any time: aborts the pending fetch and any load (a partial word is discarded), then re-enters CLEAR.
- Reset values: fetch_valid 0, fetch_err 0, fetch_data 0, fetch_ready 0, load_ready 0, load_ovf 0, load_count 0, busy 1.

## Timing
- Fetch accepted at cycle t: fetch_valid is high at t+READ_LAT for exactly one cycle.
  - fetch_ready stays low from t+1 until the response cycle, inclusive.
  - The next request is accepted at the earliest at t+READ_LAT+1.
- Error responses use the same latency as normal fetches.
- fetch_data holds its value until the next response.
- Load: the 4th accepted byte at cycle t produces the RAM write and load_count update at t+1. One byte per cycle is sustainable.
- CLEAR → IDLE: busy falls in the cycle after the last clear write.

## Structure
- Package imem_pkg holds:
  - the state enum {CLEAR, IDLE, LOAD}
  - constant NOP_WORD = 0
  - a function checking READ_LAT ∈ {1,2}
  - the legal-address helper
- Sub-module imem_ram: single-port synchronous RAM parametrised by ADDR_WIDTH and DATA_WIDTH, with one write-or-read per cycle.
  - Its output is registered.
  - READ_LAT=2 adds one further output register in imem_ctrl.
- CLEAR, LOAD and fetch all share the single RAM port. They never overlap, by FSM construction.

## Test plan
- rst for 1 cycle, then wait: busy is high for 1024 cycles (ADDR_WIDTH=10). Fetches of 0x0 and 0xFFC then return 0x00000000 with fetch_err=0.
- Load bytes 20 08 00 05 00 00 00 0C, then load_done. Required: load_count=2. Fetch 0x0 returns 0x20080005 and fetch 0x4 returns 0x0000000C, each exactly READ_LAT cycles after accept, for both READ_LAT=1 and 2.
- Fetch 0x6 and 0x1000 (ADDR_WIDTH=10): fetch_valid=1, fetch_err=1, fetch_data=0, normal latency.
- ADDR_WIDTH=2: offer 17 bytes. Required: load_ready falls after byte 16, load_ovf=1, load_count=4, and word 3 is intact.
- Load AA BB CC, then load_done: word 0 = 0xAABBCC00. Fetch together with load_start in the same cycle: the fetch returns the old word and busy rises the next cycle.
- rst after 2 bytes of a load: word 0 reads 0 after CLEAR, load_count=0, and no stray fetch_valid is produced.
